// File: rtl/goodness_ctrl_pkg.sv
// Shared types and sizing helpers for the goodness scan sequencer.
// Default geometry matches the per-core goodness EMA datapath.
package goodness_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCAN,
    ST_DRAIN,
    ST_COMPARE,
    ST_DONE
  } state_t;

  localparam int DEF_CORE_NUM           = 4;
  localparam int DEF_POST_NEUR_NUM      = 256;
  localparam int DEF_POST_NEUR_PARALLEL = 8;
  localparam int DEF_GOODNESS_WIDTH     = 20;
  localparam int DEF_MEM_RD_LAT         = 1;
  localparam int DEF_EMA_LAT            = 2;

  // Word-address width for a memory of 'depth' words, never below 1 bit.
  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Width of a down-counter that must be able to hold 'cycles'.
  function automatic int drain_width(input int cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-latency shift register that aligns read-enable with returned read data.
// A synchronous flush drops every in-flight stage in one cycle.
module valid_delay_line #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  generate
    if (STAGES == 1) begin : g_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        stage_q <= '0;
        else if (flush) stage_q <= '0;
        else            stage_q[0] <= din;
      end
    end else begin : g_multi
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        stage_q <= '0;
        else if (flush) stage_q <= '0;
        else            stage_q <= {stage_q[STAGES-2:0], din};
      end
    end
  endgenerate

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/goodness_scan_ctrl.sv
// Per-sample sequencer: clears goodness, scans membrane memory in lockstep across
// cores, drains the EMA pipeline, then snapshots goodness and thresholds it.
//
// state   | meaning
// IDLE    | waiting for start
// CLEAR   | one-cycle goodness clear to enabled cores
// SCAN    | one memory word read per cycle, addr 0..DEPTH-1
// DRAIN   | read + EMA pipeline emptying, down-counter timed
// COMPARE | snapshot avg_mem_bus and compare against threshold
// DONE    | one-cycle done pulse
module goodness_scan_ctrl
  import goodness_ctrl_pkg::*;
#(
  parameter int CORE_NUM           = DEF_CORE_NUM,
  parameter int POST_NEUR_NUM      = DEF_POST_NEUR_NUM,
  parameter int POST_NEUR_PARALLEL = DEF_POST_NEUR_PARALLEL,
  parameter int GOODNESS_WIDTH     = DEF_GOODNESS_WIDTH,
  parameter int MEM_RD_LAT         = DEF_MEM_RD_LAT,
  parameter int EMA_LAT            = DEF_EMA_LAT,
  localparam int DEPTH   = POST_NEUR_NUM / POST_NEUR_PARALLEL,
  localparam int ADDR_W  = addr_width(DEPTH),
  localparam int DRAIN_W = drain_width(MEM_RD_LAT + EMA_LAT)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               abort,
  input  logic [CORE_NUM-1:0]                core_en,
  input  logic [GOODNESS_WIDTH-1:0]          threshold,
  output logic                               busy,
  output logic                               done,
  output logic                               mem_rd_en,
  output logic [ADDR_W-1:0]                  mem_rd_addr,
  output logic [CORE_NUM-1:0]                core_valid,
  output logic [CORE_NUM-1:0]                core_clear_goodness,
  input  logic [CORE_NUM*GOODNESS_WIDTH-1:0] avg_mem_bus,
  output logic [CORE_NUM*GOODNESS_WIDTH-1:0] goodness_out,
  output logic [CORE_NUM-1:0]                goodness_pos
);

  localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(MEM_RD_LAT + EMA_LAT - 1);

  state_t                    state_q, state_nxt;
  logic [ADDR_W-1:0]         addr_q;
  logic [DRAIN_W-1:0]        drain_q;
  logic [CORE_NUM-1:0]       mask_q, mask_nxt;
  logic [GOODNESS_WIDTH-1:0] thr_q;
  logic [CORE_NUM-1:0]       pos_nxt;
  logic                      accept;
  logic                      flush;

  assign accept   = (state_q == ST_IDLE) && start && !abort;
  assign flush    = (state_q != ST_IDLE) && abort;
  assign mask_nxt = accept ? core_en : mask_q;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_nxt = ST_CLEAR;
      ST_CLEAR:   state_nxt = ST_SCAN;
      ST_SCAN:    if (addr_q == ADDR_LAST) state_nxt = ST_DRAIN;
      ST_DRAIN:   if (drain_q == '0) state_nxt = ST_COMPARE;
      ST_COMPARE: state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_comb begin
    pos_nxt = '0;
    for (int c = 0; c < CORE_NUM; c++) begin
      pos_nxt[c] = mask_q[c] & (avg_mem_bus[c*GOODNESS_WIDTH +: GOODNESS_WIDTH] >= thr_q);
    end
  end

  // Control outputs are decoded from the next state so they are registered
  // yet line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q             <= ST_IDLE;
      addr_q              <= '0;
      drain_q             <= '0;
      mask_q              <= '0;
      thr_q               <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      mem_rd_en           <= 1'b0;
      core_clear_goodness <= '0;
      goodness_out        <= '0;
      goodness_pos        <= '0;
    end else begin
      state_q   <= state_nxt;
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state_nxt == ST_DONE);
      mem_rd_en <= (state_nxt == ST_SCAN);
      core_clear_goodness <= (state_nxt == ST_CLEAR) ? mask_nxt : '0;

      if (accept) begin
        mask_q <= core_en;
        thr_q  <= threshold;
      end

      if (state_q == ST_SCAN && state_nxt == ST_SCAN) addr_q <= addr_q + ADDR_W'(1);
      else                                            addr_q <= '0;

      if (state_q == ST_SCAN)                         drain_q <= DRAIN_LOAD;
      else if (state_q == ST_DRAIN && drain_q != '0)  drain_q <= drain_q - DRAIN_W'(1);

      if (state_q == ST_COMPARE && !abort) begin
        goodness_out <= avg_mem_bus;
        goodness_pos <= pos_nxt;
      end
    end
  end

  assign mem_rd_addr = addr_q;

  valid_delay_line #(
    .WIDTH  (CORE_NUM),
    .STAGES (MEM_RD_LAT)
  ) u_valid_dly (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .din   ({CORE_NUM{mem_rd_en}} & mask_q),
    .dout  (core_valid)
  );

endmodule

// File: tb/tb_goodness_scan_ctrl.sv
// Bench for goodness_scan_ctrl: per-cycle timeline and goodness decisions are
// predicted from the start-relative schedule and plain threshold arithmetic.
module tb_goodness_scan_ctrl;

  localparam int CORE_NUM           = 4;
  localparam int POST_NEUR_NUM      = 32;
  localparam int POST_NEUR_PARALLEL = 8;
  localparam int GOODNESS_WIDTH     = 20;
  localparam int MEM_RD_LAT         = 1;
  localparam int EMA_LAT            = 2;
  localparam int DEPTH   = POST_NEUR_NUM / POST_NEUR_PARALLEL;
  localparam int ADDR_W  = 2;
  localparam int BUS_W   = CORE_NUM * GOODNESS_WIDTH;
  localparam int TOTAL   = DEPTH + MEM_RD_LAT + EMA_LAT + 3;
  localparam int CMP_CYC = TOTAL - 1;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      start = 1'b0;
  logic                      abort = 1'b0;
  logic [CORE_NUM-1:0]       core_en = '0;
  logic [GOODNESS_WIDTH-1:0] threshold = '0;
  logic                      busy, done, mem_rd_en;
  logic [ADDR_W-1:0]         mem_rd_addr;
  logic [CORE_NUM-1:0]       core_valid, core_clear_goodness, goodness_pos;
  logic [BUS_W-1:0]          avg_mem_bus = '0;
  logic [BUS_W-1:0]          goodness_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [BUS_W-1:0]    exp_gout = '0;
  logic [CORE_NUM-1:0] exp_gpos = '0;

  goodness_scan_ctrl #(
    .CORE_NUM           (CORE_NUM),
    .POST_NEUR_NUM      (POST_NEUR_NUM),
    .POST_NEUR_PARALLEL (POST_NEUR_PARALLEL),
    .GOODNESS_WIDTH     (GOODNESS_WIDTH),
    .MEM_RD_LAT         (MEM_RD_LAT),
    .EMA_LAT            (EMA_LAT)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .abort               (abort),
    .core_en             (core_en),
    .threshold           (threshold),
    .busy                (busy),
    .done                (done),
    .mem_rd_en           (mem_rd_en),
    .mem_rd_addr         (mem_rd_addr),
    .core_valid          (core_valid),
    .core_clear_goodness (core_clear_goodness),
    .avg_mem_bus         (avg_mem_bus),
    .goodness_out        (goodness_out),
    .goodness_pos        (goodness_pos)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BUS_W-1:0] rand_bus();
    logic [BUS_W-1:0] b;
    for (int c = 0; c < CORE_NUM; c++) b[c*GOODNESS_WIDTH +: GOODNESS_WIDTH] = GOODNESS_WIDTH'($urandom);
    return b;
  endfunction

  // Runs one scan starting in the current (idle) cycle, which is cycle 0.
  // abort_cyc < 0 means no abort; start stays high through cycle hold_until.
  task automatic run_scan(input string tag, input logic [CORE_NUM-1:0] mask,
                          input logic [GOODNESS_WIDTH-1:0] thr, input logic [BUS_W-1:0] final_bus,
                          input int abort_cyc, input int hold_until);
    int vcnt [CORE_NUM];
    int ecnt [CORE_NUM];
    logic e_active, e_aborted, e_rd, e_done;
    logic [CORE_NUM-1:0] e_clear, e_valid;
    logic [ADDR_W-1:0] e_addr;
    for (int c = 0; c < CORE_NUM; c++) begin vcnt[c] = 0; ecnt[c] = 0; end
    start = 1'b1; core_en = mask; threshold = thr; abort = (abort_cyc == 0);
    avg_mem_bus = rand_bus();
    for (int t = 1; t <= TOTAL + 1; t++) begin
      step();
      start       = (t <= hold_until);
      abort       = (t == abort_cyc);
      core_en     = CORE_NUM'($urandom);
      threshold   = GOODNESS_WIDTH'($urandom);
      avg_mem_bus = (t == CMP_CYC) ? final_bus : rand_bus();

      e_aborted = (abort_cyc >= 0) && (t > abort_cyc);
      e_active  = !e_aborted && (t <= TOTAL);
      e_clear   = (e_active && t == 1) ? mask : '0;
      e_rd      = e_active && (t >= 2) && (t <= DEPTH + 1);
      e_addr    = e_rd ? ADDR_W'(t - 2) : '0;
      e_valid   = (!e_aborted && t >= 2 + MEM_RD_LAT && t <= DEPTH + 1 + MEM_RD_LAT) ? mask : '0;
      e_done    = e_active && (t == TOTAL);
      if (e_done) begin
        exp_gout = final_bus;
        for (int c = 0; c < CORE_NUM; c++)
          exp_gpos[c] = mask[c] && (final_bus[c*GOODNESS_WIDTH +: GOODNESS_WIDTH] >= thr);
      end
      for (int c = 0; c < CORE_NUM; c++) begin
        if (core_valid[c]) vcnt[c]++;
        if (e_valid[c])    ecnt[c]++;
      end

      n_tests++;
      if (busy !== e_active) begin
        n_fail++; $display("FAIL %s t=%0d busy got %0b expected %0b", tag, t, busy, e_active);
      end
      n_tests++;
      if (done !== e_done) begin
        n_fail++; $display("FAIL %s t=%0d done got %0b expected %0b", tag, t, done, e_done);
      end
      n_tests++;
      if (mem_rd_en !== e_rd || mem_rd_addr !== e_addr) begin
        n_fail++; $display("FAIL %s t=%0d rd_en/addr got %0b/%0d expected %0b/%0d", tag, t, mem_rd_en, mem_rd_addr, e_rd, e_addr);
      end
      n_tests++;
      if (core_valid !== e_valid) begin
        n_fail++; $display("FAIL %s t=%0d core_valid got %b expected %b", tag, t, core_valid, e_valid);
      end
      n_tests++;
      if (core_clear_goodness !== e_clear) begin
        n_fail++; $display("FAIL %s t=%0d clear got %b expected %b", tag, t, core_clear_goodness, e_clear);
      end
      n_tests++;
      if (goodness_out !== exp_gout || goodness_pos !== exp_gpos) begin
        n_fail++; $display("FAIL %s t=%0d goodness got %h/%b expected %h/%b", tag, t, goodness_out, goodness_pos, exp_gout, exp_gpos);
      end
    end
    for (int c = 0; c < CORE_NUM; c++) begin
      n_tests++;
      if (vcnt[c] != ecnt[c]) begin
        n_fail++; $display("FAIL %s valid_count core%0d got %0d expected %0d", tag, c, vcnt[c], ecnt[c]);
      end
    end
  endtask

  task automatic test_reset();
    #3;
    n_tests++;
    if ({busy, done, mem_rd_en, mem_rd_addr, core_valid, core_clear_goodness, goodness_out, goodness_pos} !== '0) begin
      n_fail++; $display("FAIL reset outputs got busy=%0b done=%0b rd=%0b gout=%h expected all zero", busy, done, mem_rd_en, goodness_out);
    end
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_nominal();
    run_scan("nominal", 4'b1111, GOODNESS_WIDTH'($urandom), rand_bus(), -1, 0);
  endtask

  task automatic test_threshold();
    logic [BUS_W-1:0] b;
    // core3=49, core2=100, core1=50 (equal to threshold), core0=0
    b = {20'd49, 20'd100, 20'd50, 20'd0};
    run_scan("threshold", 4'b1111, 20'd50, b, -1, 0);
    n_tests++;
    if (goodness_pos !== 4'b0110) begin
      n_fail++; $display("FAIL threshold_pos got %b expected 0110", goodness_pos);
    end
  endtask

  task automatic test_mask();
    run_scan("mask", 4'b0101, 20'd10, {20'd500, 20'd11, 20'd10, 20'd10}, -1, 0);
    n_tests++;
    if (goodness_pos !== 4'b0101) begin
      n_fail++; $display("FAIL mask_pos got %b expected 0101", goodness_pos);
    end
  endtask

  task automatic test_abort();
    // Abort during the SCAN cycle reading addr 2, then start+abort together.
    run_scan("abort_scan", 4'b1111, 20'd0, rand_bus(), 4, 0);
    run_scan("abort_with_start", 4'b1111, 20'd0, rand_bus(), 0, 0);
    abort = 1'b1; start = 1'b0;
    step();
    abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_rd_en !== 1'b0 || goodness_pos !== exp_gpos) begin
      n_fail++; $display("FAIL abort_idle busy/done/rd/pos got %0b/%0b/%0b/%b expected 0/0/0/%b", busy, done, mem_rd_en, goodness_pos, exp_gpos);
    end
  endtask

  task automatic test_back_to_back();
    run_scan("start_held", 4'b1011, GOODNESS_WIDTH'($urandom), rand_bus(), -1, TOTAL);
    run_scan("restart", 4'b1110, GOODNESS_WIDTH'($urandom), rand_bus(), -1, 0);
  endtask

  task automatic test_reset_mid_scan();
    start = 1'b1; core_en = 4'b1111; threshold = 20'd1;
    for (int t = 1; t <= 7; t++) begin
      step();
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    exp_gout = '0; exp_gpos = '0;
    n_tests++;
    if ({busy, done, mem_rd_en, mem_rd_addr, core_valid, core_clear_goodness, goodness_out, goodness_pos} !== '0) begin
      n_fail++; $display("FAIL reset_mid busy=%0b done=%0b rd=%0b valid=%b gout=%h expected all zero", busy, done, mem_rd_en, core_valid, goodness_out);
    end
    #2 rst = 1'b0;
    step();
    run_scan("after_reset", 4'b1111, GOODNESS_WIDTH'($urandom), rand_bus(), -1, 0);
  endtask

  task automatic test_random();
    logic [CORE_NUM-1:0] m;
    logic [GOODNESS_WIDTH-1:0] thr;
    logic [BUS_W-1:0] b;
    int ab, hold;
    for (int i = 0; i < 12; i++) begin
      m = CORE_NUM'($urandom);
      case ($urandom_range(0, 3))
        0: thr = '0;
        1: thr = '1;
        default: thr = GOODNESS_WIDTH'($urandom);
      endcase
      b = rand_bus();
      for (int c = 0; c < CORE_NUM; c++)
        if ($urandom_range(0, 2) == 0) b[c*GOODNESS_WIDTH +: GOODNESS_WIDTH] = thr;
      ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TOTAL)) : -1;
      hold = (ab < 0) ? int'($urandom_range(0, TOTAL)) : 0;
      run_scan("random", m, thr, b, ab, hold);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_threshold();
    test_mask();
    test_abort();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
